// File: rtl/risc_ctrl_pkg.sv
// Shared definitions for the Risc run controller: FSM encoding, core opcode constants
// and default reset length.
package risc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RST1 = 3'd1,
        ST_LOAD = 3'd2,
        ST_GAP  = 3'd3,
        ST_RST2 = 3'd4,
        ST_RUN  = 3'd5,
        ST_DONE = 3'd6,
        ST_ERR  = 3'd7
    } run_state_t;

    // Core halt instruction; upper nibble of the instruction that updates OutR.
    localparam logic [15:0] HLT_OPCODE  = 16'hE001;
    localparam logic [3:0]  OUTR_PREFIX = 4'hD;

    localparam int unsigned DEF_RST_CYCLES = 9;

endpackage

// File: rtl/risc_wdog.sv
// RUN-phase watchdog: down-counter reloaded by clear, flags expiry on its terminal count.
// Only instantiated when RISC_WDOG_EN is defined.
module risc_wdog #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic sys_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            cnt <= CW'(TIMEOUT - 1);
        end else if (clear) begin
            cnt <= CW'(TIMEOUT - 1);
        end else if (enable && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // High during the TIMEOUT-th enabled cycle after the last clear.
    assign expired = enable && !clear && (cnt == '0);

endmodule

// File: rtl/risc_run_ctrl.sv
// Load-and-run sequencer for the Risc core: reset, stream program, re-reset, run, capture OutR.
// Optional RUN-phase watchdog is built in when RISC_WDOG_EN is defined.
//
// state   | meaning
// IDLE    | core held in reset, waiting for start
// RST1    | pre-load reset, RST_CYCLES cycles
// LOAD    | accepting program words, writing them to core memory
// GAP     | one cycle to let the final write land
// RST2    | post-load reset, RST_CYCLES cycles
// RUN     | core running, OutR changes recorded, waiting for done
// DONE    | one-cycle run_done pulse
// ERR     | overflow/timeout, core held until next start
module risc_run_ctrl
    import risc_ctrl_pkg::*;
#(
    parameter int unsigned DW         = 16,
    parameter int unsigned MAX_WORDS  = 256,
    parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
    parameter int unsigned TIMEOUT    = 1000000
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          start,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          s_ready,
    output logic [DW-1:0] ext_data,
    output logic          ext_we,
    output logic          PC_rst,
    input  logic [DW-1:0] OutR,
    input  logic          done,
    output logic          busy,
    output logic          run_done,
    output logic [DW-1:0] result,
    output logic [7:0]    out_cnt,
    output logic          err
);

    localparam int unsigned WC_W = $clog2(MAX_WORDS + 1);
    localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_t      state, state_nxt;
    logic [RC_W-1:0] rst_cnt;
    logic [WC_W-1:0] word_cnt;
    logic            first_run;
    logic [DW-1:0]   prev_outr;

    logic accept, overflow, start_ok, done_ok, timeout_hit, wdog_expired;

`ifdef RISC_WDOG_EN
    risc_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .sys_rst (sys_rst),
        .clear   (state != ST_RUN),
        .enable  (state == ST_RUN),
        .expired (wdog_expired)
    );
`else
    // No watchdog in this build: RUN waits for done indefinitely.
    assign wdog_expired = 1'b0 & (TIMEOUT == 0);
`endif

    always_comb begin
        state_nxt   = state;
        s_ready     = 1'b0;
        PC_rst      = 1'b0;
        busy        = 1'b1;
        run_done    = 1'b0;
        accept      = 1'b0;
        overflow    = 1'b0;
        start_ok    = 1'b0;
        done_ok     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE, ST_ERR: begin
                busy = 1'b0;
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = ST_RST1;
                end
            end
            ST_RST1: begin
                if (rst_cnt == '0) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                PC_rst   = 1'b1;
                s_ready  = 1'b1;
                accept   = s_valid;
                overflow = s_valid && (word_cnt == WC_W'(MAX_WORDS));
                if (overflow)              state_nxt = ST_ERR;
                else if (accept && s_last) state_nxt = ST_GAP;
            end
            ST_GAP: begin
                PC_rst    = 1'b1;
                state_nxt = ST_RST2;
            end
            ST_RST2: begin
                if (rst_cnt == '0) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                PC_rst      = 1'b1;
                done_ok     = done && !first_run;
                timeout_hit = wdog_expired && !done_ok;
                if (done_ok)          state_nxt = ST_DONE;
                else if (timeout_hit) state_nxt = ST_ERR;
            end
            ST_DONE: begin
                run_done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rst_cnt   <= RC_W'(RST_CYCLES - 1);
            word_cnt  <= '0;
            ext_we    <= 1'b0;
            ext_data  <= '0;
            first_run <= 1'b1;
            prev_outr <= '0;
            result    <= '0;
            out_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            // Reloads whenever not counting so each reset phase starts full.
            if ((state == ST_RST1 || state == ST_RST2) && rst_cnt != '0)
                rst_cnt <= rst_cnt - 1'b1;
            else
                rst_cnt <= RC_W'(RST_CYCLES - 1);

            ext_we <= accept && !overflow;
            if (accept && !overflow) begin
                ext_data <= s_data;
                word_cnt <= word_cnt + 1'b1;
            end

            first_run <= (state != ST_RUN);

            if (state != ST_RUN) begin
                prev_outr <= OutR;
            end else if (OutR != prev_outr) begin
                prev_outr <= OutR;
                result    <= OutR;
                if (out_cnt != 8'hFF) out_cnt <= out_cnt + 8'd1;
            end

            if (overflow || timeout_hit) err <= 1'b1;

            if (start_ok) begin
                err      <= 1'b0;
                out_cnt  <= '0;
                result   <= '0;
                word_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_risc_run_ctrl.sv
// Randomized self-checking bench for risc_run_ctrl: program streaming, reset phases,
// OutR capture, overflow, mid-load reset and the hang/watchdog behaviour.
module tb_risc_run_ctrl;
    import risc_ctrl_pkg::*;

    localparam int DW   = 16;
    localparam int MAXW = 16;
    localparam int RSTC = 9;
    localparam int TMO  = 100;

    logic          clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [DW-1:0] ext_data;
    logic          ext_we;
    logic          PC_rst;
    logic [DW-1:0] OutR = '0;
    logic          done = 1'b0;
    logic          busy;
    logic          run_done;
    logic [DW-1:0] result;
    logic [7:0]    out_cnt;
    logic          err;

    risc_run_ctrl #(
        .DW(DW), .MAX_WORDS(MAXW), .RST_CYCLES(RSTC), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .sys_rst(sys_rst), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .ext_data(ext_data), .ext_we(ext_we), .PC_rst(PC_rst),
        .OutR(OutR), .done(done), .busy(busy), .run_done(run_done),
        .result(result), .out_cnt(out_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] wr_q[$];
    int            rd_cnt = 0;
    logic [DW-1:0] prog[0:63];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observe core-memory writes and done pulses mid-cycle.
    always @(negedge clk) begin
        if (sys_rst) begin
            if (ext_we) wr_q.push_back(ext_data);
            if (run_done) rd_cnt++;
        end
    end

    task automatic check_writes(input int n);
        check("wr_count", wr_q.size(), n);
        for (int i = 0; i < n && i < wr_q.size(); i++)
            check($sformatf("wr_data[%0d]", i), wr_q[i], prog[i]);
    endtask

    task automatic fill_prog(input int n);
        for (int i = 0; i < n; i++)
            prog[i] = (i % 3 == 1) ? {OUTR_PREFIX, 12'($urandom)} : 16'($urandom);
        prog[n-1] = HLT_OPCODE;
    endtask

    // mode: 0 = s_valid constant, 1 = every other cycle, 2 = random
    task automatic do_run(input int n, input int mode, input bit ovf, input int n_out,
                          input bit p_same, input bit start_mid, input bit hang);
        int            acc, cyc, lo, rd0, exp_cnt, n_acc, c;
        bit            v, rdy;
        logic [DW-1:0] prev, val, exp_res;
        wr_q.delete();
        rd0 = rd_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_cleared_on_start", err, 0);
        check("result_cleared_on_start", result, 0);
        lo = 0;
        while (PC_rst == 1'b0 && lo < 50) begin lo++; step(); end
        check("rst1_len", lo, RSTC);

        n_acc = ovf ? MAXW + 1 : n;
        acc = 0;
        cyc = 0;
        while (acc < n_acc && cyc < 1000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            s_valid = v;
            s_data  = prog[acc];
            s_last  = !ovf && (acc == n - 1);
            rdy     = s_ready;
            step();
            if (v && rdy) acc++;
            cyc++;
        end
        check("load_accepts", acc, n_acc);
        s_data  = 16'hDEAD;
        s_last  = 1'b0;
        s_valid = 1'b1;
        check("ready_after_load", s_ready, 0);
        step();
        s_valid = 1'b0;
        if (ovf) begin
            step();
            check("ovf_err", err, 1);
            check("ovf_pc_rst", PC_rst, 0);
            check("ovf_busy", busy, 0);
            check("ovf_ready", s_ready, 0);
            check_writes(MAXW);
            return;
        end

        lo = 0;
        while (PC_rst == 1'b0 && lo < 50) begin lo++; step(); end
        check("rst2_len", lo, RSTC);
        check_writes(n);

        // First RUN cycle: done must be ignored.
        check("run_busy", busy, 1);
        done = 1'b1;
        step();
        done = 1'b0;
        check("done_first_ignored", run_done, 0);

        if (hang) begin
`ifdef RISC_WDOG_EN
            c = 1;
            while (!err && c < 500) begin step(); c++; end
            check("wdog_cycles", c, TMO);
            check("wdog_busy", busy, 0);
            check("wdog_pc_rst", PC_rst, 0);
            return;
`else
            repeat (300) step();
            check("no_wdog_busy", busy, 1);
            check("no_wdog_err", err, 0);
`endif
        end

        prev    = OutR;
        exp_cnt = 0;
        exp_res = '0;
        for (int k = 0; k < n_out; k++) begin
            repeat ($urandom_range(0, 2)) step();
            if (p_same && $urandom_range(0, 3) == 0) val = prev;
            else                                     val = prev + 16'($urandom_range(1, 200));
            OutR = val;
            if (val != prev) begin exp_cnt++; exp_res = val; end
            prev = val;
            if (start_mid && k == n_out / 2) start = 1'b1;
            step();
            start = 1'b0;
        end
        // OutR change in the same cycle as done is still recorded.
        val = prev + 16'd3;
        OutR = val;
        exp_cnt++;
        exp_res = val;
        done = 1'b1;
        step();
        done = 1'b0;
        check("run_done_pulse", run_done, 1);
        check("done_pc_rst", PC_rst, 0);
        step();
        check("idle_busy", busy, 0);
        check("idle_pc_rst", PC_rst, 0);
        check("run_done_once", rd_cnt - rd0, 1);
        check("result", result, exp_res);
        check("out_cnt", out_cnt, (exp_cnt > 255) ? 255 : exp_cnt);
        check("err_after_run", err, 0);
    endtask

    initial begin
        #1;
        check("rst_pc_rst", PC_rst, 0);
        check("rst_ext_we", ext_we, 0);
        check("rst_ext_data", ext_data, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_run_done", run_done, 0);
        check("rst_result", result, 0);
        check("rst_out_cnt", out_cnt, 0);
        check("rst_err", err, 0);
        repeat (3) @(posedge clk);
        #1 sys_rst = 1'b1;
        step();

        // Reference add program, s_valid held high.
        prog[0] = 16'h8AA0; prog[1] = 16'h99C0; prog[2] = 16'h0204;
        prog[3] = 16'h2AE0; prog[4] = HLT_OPCODE;
        do_run(5, 0, 1'b0, 4, 1'b1, 1'b0, 1'b0);

        // 12-word program with s_valid toggling.
        fill_prog(12);
        do_run(12, 1, 1'b0, 2, 1'b0, 1'b0, 1'b0);

        // Reset mid-LOAD aborts everything immediately.
        fill_prog(8);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (RSTC) step();
        check("load_pc_rst", PC_rst, 1);
        s_valid = 1'b1;
        s_data  = prog[0];
        repeat (3) step();
        #2 sys_rst = 1'b0;
        #1;
        check("midrst_ext_we", ext_we, 0);
        check("midrst_s_ready", s_ready, 0);
        check("midrst_pc_rst", PC_rst, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ext_data", ext_data, 0);
        s_valid = 1'b0;
        @(posedge clk);
        #1 sys_rst = 1'b1;
        step();
        do_run(8, 2, 1'b0, 5, 1'b1, 1'b0, 1'b0);

        // Random valid pattern, start pulsed during RUN.
        fill_prog(9);
        do_run(9, 2, 1'b0, 6, 1'b1, 1'b1, 1'b0);

        // Overflow: MAXW+1 words without s_last.
        fill_prog(MAXW + 1);
        do_run(MAXW + 1, 2, 1'b1, 0, 1'b0, 1'b0, 1'b0);

        // Exactly MAXW words with s_last, started from ERR.
        fill_prog(MAXW);
        do_run(MAXW, 2, 1'b0, 3, 1'b1, 1'b0, 1'b0);

        // Core never reports done.
        fill_prog(3);
        do_run(3, 0, 1'b0, 2, 1'b0, 1'b0, 1'b1);

`ifndef RISC_WDOG_EN
        // out_cnt saturation.
        fill_prog(4);
        do_run(4, 0, 1'b0, 270, 1'b0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
